// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared constants and FSM encoding for the round-robin decoder arbiter.
// No logic, so no latency; no flow control.
// Backpressure: not applicable.
package rr_arb_pkg;

    localparam int N_REQ           = 8;
    localparam int IDX_W           = 3;
    localparam int SLOT_CYCLES_DEF = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter feeding decoder3_to_8.
// Latency: wires only.
// Backpressure: req is a level held until served; rel is a one-cycle pulse from the grantee.
interface rr_decoder_arbiter_if;
    import rr_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             rel;
    logic [IDX_W-1:0] sel_w;
    logic             sel_en;
    logic             busy;

    modport master (
        output req,
        output rel,
        input  sel_w,
        input  sel_en,
        input  busy
    );

    modport slave (
        input  req,
        input  rel,
        output sel_w,
        output sel_en,
        output busy
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set req bit searching upward from ptr, wrapping at 7.
// Latency: purely combinational.
// Backpressure: none; idx is meaningful only when any_req is high.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any_req,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        any_req = |req;
        idx     = '0;
        found   = 1'b0;
        cand    = '0;
        // Index arithmetic in IDX_W bits gives the wrap 7 -> 0 for free.
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin owner of one decoder3_to_8, with a one-cycle all-zero gap between grants (SLOT_TIMEOUT_EN adds slot preemption).
// Latency: req sampled at edge t drives sel_en high after edge t; exit drops sel_en after the next edge.
// Backpressure: requests hold their level until granted; a grant ends on rel, withdrawal, or slot timeout.
module rr_decoder_arbiter
    import rr_arb_pkg::*;
`ifdef SLOT_TIMEOUT_EN
#(
    parameter int SLOT_CYCLES = SLOT_CYCLES_DEF
)
`endif
(
    input  logic                 clk,
    input  logic                 reset,
    rr_decoder_arbiter_if.slave  bus
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] sel_w_q, sel_w_d;
    logic             any_req;
    logic [IDX_W-1:0] pick_idx;
    logic             timeout;
    logic             grant_exit;

    rr_pick u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .any_req (any_req),
        .idx     (pick_idx)
    );

`ifdef SLOT_TIMEOUT_EN
    localparam logic [7:0] CNT_MAX = 8'(SLOT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic       others_pending;

    assign others_pending = |(bus.req & ~(N_REQ'(1) << sel_w_q));
    assign timeout        = (cnt_q == CNT_MAX) && others_pending;

    // Counter sits at zero outside GRANT, so entry into GRANT always starts a fresh slot.
    always_ff @(posedge clk) begin
        if (reset || state_q != ST_GRANT || grant_exit) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign grant_exit = bus.rel || !bus.req[sel_w_q] || timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_w_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_w_q <= sel_w_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_w_d = sel_w_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_GRANT;
                    sel_w_d = pick_idx;
                end
            end
            ST_GRANT: begin
                // Returning to IDLE forces the one-cycle sel_en=0 gap before the next grant.
                if (grant_exit) begin
                    state_d = ST_IDLE;
                    ptr_d   = sel_w_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.sel_w  = sel_w_q;
    assign bus.sel_en = (state_q == ST_GRANT);
    assign bus.busy   = (state_q == ST_GRANT);

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- Round-robin arbiter that shares one decoder3_to_8 among 8 requesters.
- Drives the decoder's select (w) and enable (en) so exactly one requester's line is active at a time.
- Guarantees a one-cycle break-before-make gap between grants, during which the decoder output is all-zero.
- Sits directly upstream of decoder3_to_8; requesters are the 8 consumers of its one-hot output.

Parameters:
- N_REQ, 8, number of requesters; fixed to match the decoder's 8 outputs.
- IDX_W, 3, width of the select index; equals log2(N_REQ).
- SLOT_CYCLES, 4, maximum cycles a grant is held while other requests are pending (used only with SLOT_TIMEOUT_EN); legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request per requester; level, held until served.
- release  input  1  one-cycle pulse from the current grantee ending its grant.
- sel_w  output  3  index of the granted requester; connects to decoder w.
- sel_en  output  1  grant active; connects to decoder en.
- busy  output  1  high while in GRANT state.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: sel_w=0, sel_en=0, busy=0, state=IDLE, rotation pointer ptr=0, slot counter=0.
- FSM states: IDLE, GRANT (2 states).
- IDLE, no req bit set: stay in IDLE; outputs hold sel_en=0; sel_w keeps its last value.
- IDLE, any req bit set: pick the first set bit searching upward from ptr with wrap (ptr, ptr+1, ..., 7, 0, ..., ptr-1).
  - On the next edge: sel_w=winner, sel_en=1, busy=1, go to GRANT, counter=0.
  - Latency: req sampled at edge t gives sel_en high after edge t (1 cycle).
- GRANT exits to IDLE on the next edge if any of the following holds:
  - release=1;
  - req[sel_w]=0 (requester withdrew);
  - timeout (feature only).
- On exit: sel_en=0, busy=0, ptr=sel_w+1 modulo 8 (7 wraps to 0).
  - sel_en stays low for at least one full cycle before the next grant (break-before-make).
- Release and timeout in the same cycle: treat as a single exit; ptr update is identical.
- release while in IDLE: ignored.
- req changes during GRANT: no effect except on req[sel_w].
- Fairness: a continuously requesting line waits at most 7 grants.
- Reset asserted mid-grant: sel_en=0 after that edge; pending requests are re-arbitrated from ptr=0 once reset deasserts.
- sel_w is stable for the whole grant; sel_w changes only on the IDLE->GRANT edge.

Optional Feature:
- Macro: SLOT_TIMEOUT_EN.
- Defined:
  - In GRANT, the counter increments each cycle and saturates at SLOT_CYCLES-1.
  - If counter==SLOT_CYCLES-1 and any other req bit is set, exit to IDLE on that edge (preemption).
  - With no other requester, the grant continues indefinitely.
  - Counter clears on entry to GRANT.
- Undefined: no counter logic; a grant ends only on release or withdrawal.

Decomposition:
- Package rr_arb_pkg holds:
  - state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1;
  - constants N_REQ and IDX_W;
  - default SLOT_CYCLES.
- Sub-module rr_pick: purely combinational rotating priority picker.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any_req, idx[2:0].
  - Verified standalone exhaustively (256 req values x 8 ptr values).
- Top level holds the FSM, ptr, and counter registers.

Test Plan:
- Reset, then req=8'b0000_0100 -> sel_w=2 and sel_en=1 one cycle later; release pulse -> sel_en=0 next cycle; ptr=3.
- req=8'hFF held, release pulsed every 3 cycles -> grant order 0,1,2,...,7,0, each grant separated by exactly one sel_en=0 cycle.
- ptr=6 (after serving 5), req=8'b0100_0001 -> grant 6, then 0 (wrap check); never 0 first.
- Grant to 4, then drop req[4] without release -> sel_en=0 next cycle; release arriving in IDLE is ignored.
- SLOT_TIMEOUT_EN with SLOT_CYCLES=4: grant 1, req=8'b0000_1010, no release -> preempted after 4 GRANT cycles, then 3 is granted. Repeat with only req[1] set -> no preemption over 20 cycles.
- reset asserted during grant to 5 -> sel_en=0, busy=0 after the edge; with req[5] and req[7] still set after reset deasserts -> 5 is granted first (ptr=0 search).
